// File: rtl/bus_mux_arb.sv
// N-channel to one multiplexer with a registered output stage.
// Channel choice is either a direct select or round-robin arbitration.
module bus_mux_arb #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_ready
);

  logic            accept;
  logic            grant_valid;
  logic [SELW-1:0] grant;
  logic [SELW-1:0] ptr;
  logic [WIDTH-1:0] grant_data;

  // A new word can be taken when the output register is empty or draining this cycle.
  assign accept = !out_valid || out_ready;

  // Grant selection; round-robin searches from the channel after the last winner.
  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant       = '0;
    idx         = 0;
    if (mode) begin
      for (int k = 1; k <= NCH; k++) begin
        idx = (int'(ptr) + k) % NCH;
        if (!grant_valid && in_valid[idx]) begin
          grant_valid = 1'b1;
          grant       = SELW'(idx);
        end
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          grant_valid = 1'b1;
          grant       = SELW'(i);
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant == SELW'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Reset masks the handshake so a transfer can never coincide with reset.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      in_ready[i] = !rst && accept && grant_valid && (grant == SELW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= SELW'(NCH - 1);
    end else if (accept) begin
      if (grant_valid) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_ch    <= grant;
        if (mode) begin
          ptr <= grant;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/bus_mux_arb.md
BUS_MUX_ARB -- requirements
Module: bus_mux_arb

Interface
REQ-001 Parameter WIDTH, default 8, data width per channel in bits.
REQ-002 Parameter NCH, default 4, number of input channels; legal range 2..16.
REQ-003 Parameter SELW, default 2, select/channel-index width; SHALL equal ceil(log2(NCH)).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 mode  input  1  0 = direct select, 1 = round-robin arbitration.
REQ-007 sel  input  SELW  channel index used in direct mode; ignored in round-robin mode.
REQ-008 in_data  input  NCH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 in_valid  input  NCH  per-channel valid.
REQ-010 in_ready  output  NCH  per-channel ready; combinational from state, mode, sel, in_valid, out_ready.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_valid  output  1  registered output valid.
REQ-013 out_ch  output  SELW  registered index of the channel that sourced out_data.
REQ-014 out_ready  input  1  downstream ready.

Function
REQ-015 Transfer on input i SHALL occur in a cycle where in_valid[i] and in_ready[i] are both 1; output transfer when out_valid and out_ready are both 1.
REQ-016 accept = !out_valid || out_ready; the block SHALL take a new word only when accept = 1.
REQ-017 Direct mode: grant = sel when sel < NCH and in_valid[sel] = 1; otherwise no grant.
REQ-018 Direct mode, sel >= NCH: no grant, all in_ready = 0, no error output.
REQ-019 Round-robin mode: grant = first i with in_valid[i] = 1, searching ptr+1, ptr+2, ... modulo NCH, wrapping past NCH-1 to 0; no valid input means no grant.
REQ-020 ptr (SELW bits, internal) SHALL update to the granted index only on a round-robin transfer; direct-mode transfers leave ptr unchanged.
REQ-021 in_ready[i] = accept && grant valid && grant == i; at most one in_ready bit high per cycle.
REQ-022 On transfer: out_data <= granted channel data, out_ch <= grant, out_valid <= 1; latency input-to-output exactly 1 cycle.
REQ-023 accept = 1 and no grant: out_valid <= 0; out_data and out_ch hold their previous values.
REQ-024 out_valid = 1 and out_ready = 0: out_data, out_ch, out_valid SHALL hold stable; all in_ready = 0.
REQ-025 Simultaneous output drain and new grant in one cycle SHALL sustain one word per cycle with no bubble.
REQ-026 mode and sel changes SHALL take effect in the same cycle's grant computation; a held output word is unaffected.
REQ-027 No word SHALL be dropped or duplicated: each input transfer produces exactly one output transfer, in order.

Reset
REQ-028 While rst = 1 at a clock edge: out_valid <= 0, out_data <= 0, out_ch <= 0, ptr <= NCH-1 (first round-robin search starts at channel 0).
REQ-029 While rst = 1, all in_ready SHALL be 0; any held output word is discarded.
REQ-030 Reset asserted mid-stream SHALL take priority over any simultaneous transfer.

Verification
REQ-031 Reset: rst = 1 for 2 cycles with all in_valid = 1 -> out_valid = 0, out_data = 0, out_ch = 0, in_ready = 0; first RR grant after release is channel 0.
REQ-032 Direct mode, sel = 2, in_valid = 4'b1111, channel 2 data = 8'hA5, out_ready = 1 -> in_ready = 4'b0100; next cycle out_data = 8'hA5, out_ch = 2, out_valid = 1.
REQ-033 RR mode, in_valid = 4'b1111 held, out_ready = 1 -> grant sequence 0,1,2,3,0,1 on consecutive cycles, one output per cycle.
REQ-034 RR mode, in_valid = 4'b1010 -> grants alternate 1,3,1,3; channels 0 and 2 never granted.
REQ-035 Backpressure: out_valid = 1 with out_ch = 1, out_ready = 0 for 3 cycles -> out_data/out_ch stable, in_ready = 0; on out_ready = 1, same-cycle grant of next channel and no bubble.
REQ-036 NCH = 3, direct mode, sel = 3 with in_valid = 3'b111 -> in_ready = 0 and out_valid falls to 0 after the pending word drains.
